// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared constants for the operand fetch sequencer and the register selector:
// sequencer state encoding and operand select codes.
package operand_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4,
        PH5  = 3'd5,
        PH6  = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [3:0] SEL_ESP1 = 4'd1;
    localparam logic [3:0] SEL_EBP  = 4'd2;
    localparam logic [3:0] SEL_IMM  = 4'd3;
    localparam logic [3:0] SEL_ESP2 = 4'd4;

    function automatic logic sel_is_legal(input logic [3:0] code);
        return (code == SEL_ESP1) || (code == SEL_EBP) ||
               (code == SEL_IMM)  || (code == SEL_ESP2);
    endfunction

endpackage

// File: rtl/operand_fetch_sequencer_capture.sv
// One operand slot: picks register or immediate by select code and holds the
// result until the next capture; illegal codes capture zero.
module operand_capture
    import operand_fetch_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        capture,
    input  logic [3:0]  code,
    input  logic [31:0] imm,
    input  logic [31:0] reg_val,
    output logic [31:0] value,
    output logic        illegal
);

    logic [31:0] src;

    always_comb begin
        src = '0;
        case (code)
            SEL_ESP1, SEL_EBP, SEL_ESP2: src = reg_val;
            SEL_IMM:                     src = imm;
            default:                     src = '0;
        endcase
    end

    assign illegal = !sel_is_legal(code);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            value <= '0;
        else if (capture)
            value <= src;
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Fixed eight-cycle sequence that strobes the register selector for two
// operands (PH4 for A, PH6 for B) and captures each on the following edge.
module operand_fetch_sequencer
    import operand_fetch_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  sel_1_in,
    input  logic [3:0]  sel_2_in,
    input  logic [31:0] imm_data,
    input  logic [31:0] registor_output,
    output logic        clock_4,
    output logic        clock_6,
    output logic [3:0]  select_1,
    output logic [3:0]  select_2,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic        sel_error
);

    state_t      state, state_next;
    logic [31:0] imm_q;
    logic        cap_a, cap_b;
    logic        illegal_a, illegal_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clock_4    = 1'b0;
        clock_6    = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        sel_error  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = PH1;
            end
            PH1: state_next = PH2;
            PH2: state_next = PH3;
            PH3: state_next = PH4;
            PH4: begin
                clock_4    = 1'b1;
                cap_a      = 1'b1;
                state_next = PH5;
            end
            PH5: state_next = PH6;
            PH6: begin
                clock_6    = 1'b1;
                cap_b      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                sel_error  = illegal_a | illegal_b;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched only on acceptance; start while busy is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            select_1 <= '0;
            select_2 <= '0;
            imm_q    <= '0;
        end else if (state == IDLE && start) begin
            select_1 <= sel_1_in;
            select_2 <= sel_2_in;
            imm_q    <= imm_data;
        end
    end

    operand_capture u_cap_a (
        .clock   (clock),
        .reset   (reset),
        .capture (cap_a),
        .code    (select_1),
        .imm     (imm_q),
        .reg_val (registor_output),
        .value   (operand_a),
        .illegal (illegal_a)
    );

    operand_capture u_cap_b (
        .clock   (clock),
        .reset   (reset),
        .capture (cap_b),
        .code    (select_2),
        .imm     (imm_q),
        .reg_val (registor_output),
        .value   (operand_b),
        .illegal (illegal_b)
    );

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench: requests push expected results, a negedge monitor pops
// and checks them whenever done is presented.
module tb_operand_fetch_sequencer;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
        logic [3:0]  s1;
        logic [3:0]  s2;
        int          done_cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  sel_1_in = '0;
    logic [3:0]  sel_2_in = '0;
    logic [31:0] imm_data = '0;
    logic [31:0] registor_output;
    logic        clock_4, clock_6, busy, done, sel_error;
    logic [3:0]  select_1, select_2;
    logic [31:0] operand_a, operand_b;

    logic [31:0] ph4_val = '0;
    logic [31:0] ph6_val = '0;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   c4_cnt = 0;
    int   c6_cnt = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic        have_last = 1'b0;

    // Register selector model: only answers while the matching strobe is high.
    assign registor_output = clock_4 ? ph4_val : (clock_6 ? ph6_val : 32'hBAD0_BAD0);

    operand_fetch_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .sel_1_in        (sel_1_in),
        .sel_2_in        (sel_2_in),
        .imm_data        (imm_data),
        .registor_output (registor_output),
        .clock_4         (clock_4),
        .clock_6         (clock_6),
        .select_1        (select_1),
        .select_2        (select_2),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .busy            (busy),
        .done            (done),
        .sel_error       (sel_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        if (!reset) begin
            check("strobe_onehot", {31'd0, clock_4 & clock_6}, 32'd0);
            if (clock_4) begin
                c4_cnt++;
                if (sb.size() != 0) check("select_1_at_ph4", {28'd0, select_1}, {28'd0, sb[0].s1});
            end
            if (clock_6) begin
                c6_cnt++;
                if (sb.size() != 0) check("select_2_at_ph6", {28'd0, select_2}, {28'd0, sb[0].s2});
            end
            if (!done && sel_error) check("sel_error_without_done", 32'd1, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("operand_a", operand_a, e.a);
                    check("operand_b", operand_b, e.b);
                    check("sel_error", {31'd0, sel_error}, {31'd0, e.err});
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_in_done", {31'd0, busy}, 32'd1);
                    check("clock_4_pulses", c4_cnt, 1);
                    check("clock_6_pulses", c6_cnt, 1);
                end
                c4_cnt = 0;
                c6_cnt = 0;
            end
        end else begin
            c4_cnt = 0;
            c6_cnt = 0;
        end
    end

    // Wait for the scoreboard to drain, then step into the following IDLE cycle.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clock); #1;
        check("busy_idle", {31'd0, busy}, 32'd0);
        if (have_last) begin
            check("hold_operand_a", operand_a, last_a);
            check("hold_operand_b", operand_b, last_b);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic err,
                        input logic [3:0] s1, input logic [3:0] s2);
        exp_t e;
        e.a = a; e.b = b; e.err = err; e.s1 = s1; e.s2 = s2;
        e.done_cyc = cyc + 6;
        sb.push_back(e);
        last_a = a; last_b = b; have_last = 1'b1;
    endtask

    // Single request; caller guarantees the DUT is in IDLE now.
    task automatic req(input logic [3:0] s1, input logic [3:0] s2, input logic [31:0] imm,
                       input logic [31:0] r4, input logic [31:0] r6,
                       input logic [31:0] ea, input logic [31:0] eb, input logic err);
        sel_1_in = s1; sel_2_in = s2; imm_data = imm;
        ph4_val = r4; ph6_val = r6;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        sel_1_in = 4'hF; sel_2_in = 4'hF; imm_data = 32'h0BAD_0BAD;
        push(ea, eb, err, s1, s2);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobes", {30'd0, clock_4, clock_6}, 32'd0);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_operand_b", operand_b, 32'd0);
        check("rst_selects", {24'd0, select_1, select_2}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed vectors
        req(4'd1, 4'd2, 32'h0,         32'h100,  32'h200, 32'h100,      32'h200,      1'b0);
        req(4'd3, 4'd4, 32'hDEADBEEF,  32'h1234, 32'h55,  32'hDEADBEEF, 32'h55,       1'b0);
        req(4'd0, 4'd7, 32'h1111_1111, 32'hAAAA, 32'hBBBB, 32'h0,       32'h0,        1'b1);
        req(4'd2, 4'd3, 32'hCAFEF00D,  32'h77,   32'h88,  32'h77,       32'hCAFEF00D, 1'b0);
        req(4'd15, 4'd1, 32'h0,        32'h99,   32'h66,  32'h0,        32'h66,       1'b1);
        req(4'd4, 4'd5, 32'h0,         32'h4444, 32'h5555, 32'h4444,    32'h0,        1'b1);

        // Start held high: only edges 0, 8, 16 latch; junk codes in between must be ignored.
        ph4_val = 32'h0; ph6_val = 32'h0;
        start = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            sel_1_in = (i % 8 == 0) ? 4'd3 : 4'd0;
            sel_2_in = (i % 8 == 0) ? 4'd3 : 4'd9;
            imm_data = 32'h1000 + i;
            @(posedge clock); #1;
            if (i % 8 == 0) push(32'h1000 + i, 32'h1000 + i, 1'b0, 4'd3, 4'd3);
        end
        start = 1'b0;
        wait_idle();

        // Async reset in PH5, after operand A has been captured.
        sel_1_in = 4'd1; sel_2_in = 4'd2; ph4_val = 32'h7777; ph6_val = 32'h8888;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        push(32'h7777, 32'h8888, 1'b0, 4'd1, 4'd2);
        repeat (4) @(posedge clock);
        #2;
        check("pre_reset_operand_a", operand_a, 32'h7777);
        reset = 1'b1;
        sb.delete();
        have_last = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done_err", {30'd0, done, sel_error}, 32'd0);
        check("arst_strobes", {30'd0, clock_4, clock_6}, 32'd0);
        check("arst_operand_a", operand_a, 32'd0);
        check("arst_operand_b", operand_b, 32'd0);
        check("arst_selects", {24'd0, select_1, select_2}, 32'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("no_done_after_reset", {31'd0, busy}, 32'd0);
        req(4'd2, 4'd4, 32'h0, 32'h1357, 32'h2468, 32'h1357, 32'h2468, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
